fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder: owns the program counter, issues word reads to instruction memory over a req/ack handshake and buffers returned words in a 2-entry FIFO. Buffered words go to the decoder over a valid/ready interface, each tagged with its PC. A redirect from the branch/execute stage flushes buffered and in-flight fetches and restarts fetch at the new target.

---
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit (rev 1.0): owns the PC, fetches words over req/ack and buffers two {pc, word} entries for the decoder.
// Optional macro FETCH_ALIGN_CHECK_EN traps misaligned redirects into a HALT state.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault,
   output logic [31:0] fault_pc
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
      , HALT  = 2'd3
`endif
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt, req_addr, issue_addr, target;
   logic [31:0] fifo_pc   [2];
   logic [31:0] fifo_word [2];
   logic [1:0]  count, cnt_pop;
   logic        pop, ack, push, issue, flush, redir, trap;

   assign pop         = instr_valid & instr_ready;
   assign ack         = mem_req & mem_ack;
   assign cnt_pop     = count - {1'b0, pop};
   assign instr_valid = (count != 2'd0);
   assign instruction = fifo_word[0];
   assign instr_pc    = fifo_pc[0];
   assign mem_addr    = req_addr;

`ifdef FETCH_ALIGN_CHECK_EN
   logic        halt_wait, fault_q;
   logic [31:0] fault_pc_q;

   assign redir       = redirect_valid & (state != HALT);
   assign trap        = redir & (redirect_pc[1:0] != 2'b00);
   assign target      = redirect_pc;
   // HALT keeps the bus request up only until the in-flight read completes
   assign mem_req     = (state == REQ) | (state == DISCARD) | ((state == HALT) & halt_wait);
   assign fetch_fault = fault_q;
   assign fault_pc    = fault_pc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halt_wait  <= 1'b0;
         fault_q    <= 1'b0;
         fault_pc_q <= 32'h0;
      end else if (trap) begin
         halt_wait  <= mem_req & ~mem_ack;
         fault_q    <= 1'b1;
         fault_pc_q <= redirect_pc;
      end else if (ack) begin
         halt_wait  <= 1'b0;
      end
   end
`else
   logic unused_low;

   assign unused_low  = ^redirect_pc[1:0];
   assign redir       = redirect_valid;
   assign trap        = 1'b0;
   assign target      = {redirect_pc[31:2], 2'b00};
   assign mem_req     = (state == REQ) | (state == DISCARD);
   assign fetch_fault = 1'b0;
   assign fault_pc    = 32'h0;
`endif

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      issue      = 1'b0;
      issue_addr = pc;
      push       = 1'b0;
      flush      = 1'b0;
      if (redir) begin
         flush  = 1'b1;
         pc_nxt = target;
         if (trap) begin
`ifdef FETCH_ALIGN_CHECK_EN
            state_nxt = HALT;
`endif
         end else if (ack || state == IDLE) begin
            state_nxt  = REQ;
            issue      = 1'b1;
            issue_addr = target;
         end else begin
            state_nxt = DISCARD;
         end
      end else begin
         case (state)
            IDLE: begin
               if (cnt_pop < 2'd2) begin
                  state_nxt = REQ;
                  issue     = 1'b1;
               end
            end
            REQ: begin
               if (ack) begin
                  push   = 1'b1;
                  pc_nxt = pc + 32'd4;
                  // the pushed word brings occupancy to cnt_pop + 1; keep fetching only if that leaves room
                  if (cnt_pop == 2'd0) begin
                     issue      = 1'b1;
                     issue_addr = pc + 32'd4;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
            DISCARD: begin
               if (ack) begin
                  state_nxt = REQ;
                  issue     = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc           <= RESET_PC;
         req_addr     <= RESET_PC;
         count        <= 2'd0;
         fifo_pc[0]   <= 32'h0;
         fifo_pc[1]   <= 32'h0;
         fifo_word[0] <= 32'h0;
         fifo_word[1] <= 32'h0;
      end else begin
         pc <= pc_nxt;
         if (issue) req_addr <= issue_addr;
         if (flush) begin
            count <= 2'd0;
         end else begin
            count <= cnt_pop + {1'b0, push};
            if (pop) begin
               fifo_pc[0]   <= fifo_pc[1];
               fifo_word[0] <= fifo_word[1];
            end
            if (push) begin
               if (cnt_pop == 2'd0) begin
                  fifo_pc[0]   <= req_addr;
                  fifo_word[0] <= mem_rdata;
               end else begin
                  fifo_pc[1]   <= req_addr;
                  fifo_word[1] <= mem_rdata;
               end
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: table of stall/drain vectors, directed redirect sequences and a random run
// against a stream-level model (expected PC sequence, word = function of address).
module tb_fetch_unit;
   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req, mem_ack, instr_valid, instr_ready, redirect_valid, fetch_fault;
   logic [31:0] mem_addr, mem_rdata, instruction, instr_pc, redirect_pc, fault_pc;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .instr_pc(instr_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_fault(fetch_fault), .fault_pc(fault_pc)
   );

   int          checks = 0, errors = 0;
   int          lat = 0, wcnt = 0, pops = 0;
   bit          rnd_lat = 1'b0;
   logic [31:0] exp_pc;
   bit          stale, halted, hold, vknown, vexp;
   logic [31:0] hold_addr;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
      mem_ack = 1'b1; wcnt = 0;
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_addr", mem_addr, RPC);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_fault", 32'(fetch_fault), 32'h0);
      chk("rst_fault_pc", fault_pc, 32'h0);
      reset = 1'b0;
      exp_pc = RPC; stale = 1'b0; halted = 1'b0; hold = 1'b0; vknown = 1'b0;
   endtask

   // One clock: drive inputs, answer memory, check invariants and the decoder-side stream.
   task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc);
      bit fire;
      @(negedge clk);
      instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      if (mem_req) begin
         mem_ack   = (wcnt >= lat);
         mem_rdata = mem_ack ? memw(mem_addr) : $urandom;
         if (mem_ack) begin
            wcnt = 0;
            if (rnd_lat) lat = $urandom_range(0, 3);
         end else begin
            wcnt++;
         end
      end else begin
         mem_ack   = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         wcnt      = 0;
      end
      if (hold) begin
         chk("addr_hold_req", 32'(mem_req), 32'h1);
         chk("addr_hold", mem_addr, hold_addr);
      end
      if (vknown) chk("valid_next", 32'(instr_valid), 32'(vexp));
      if (halted) begin
         chk("halt_valid", 32'(instr_valid), 32'h0);
         if (!stale) chk("halt_req", 32'(mem_req), 32'h0);
      end
      fire   = mem_req && mem_ack;
      vknown = 1'b0;
      if (halted) begin
         if (fire) stale = 1'b0;
      end else if (rv) begin
         vknown = 1'b1; vexp = 1'b0;
         stale  = mem_req && !mem_ack;
`ifdef FETCH_ALIGN_CHECK_EN
         if (rpc[1:0] != 2'b00) halted = 1'b1;
`endif
         exp_pc = {rpc[31:2], 2'b00};
      end else begin
         if (instr_valid && rdy) begin
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_word", instruction, memw(exp_pc));
            exp_pc += 32'd4;
            pops++;
         end
         if (fire) begin
            vknown = 1'b1; vexp = !stale; stale = 1'b0;
         end
      end
      hold      = mem_req && !mem_ack;
      hold_addr = mem_addr;
   endtask

   typedef struct {
      int lat;
      int stall;
      int drain_lat;
      bit exp_req;
      bit exp_v0;
      bit exp_v1;
      bit exp_v2;
   } vec_t;

   vec_t tbl [4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      bit found;
      logic [31:0] rpc;
      reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
      instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

      tbl[0] = '{0, 12, 3, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{1, 12, 0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[2] = '{3, 14, 2, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{2, 12, 1, 1'b0, 1'b1, 1'b1, 1'b0};

      // zero-wait streaming from reset
      lat = 0;
      do_reset();
      cycle(1, 0, 0);
      chk("c1_req", 32'(mem_req), 32'h1);
      chk("c1_addr", mem_addr, RPC);
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, 0);
         chk("stream_valid", 32'(instr_valid), 32'h1);
         chk("stream_req", 32'(mem_req), 32'h1);
      end

      // decoder stall fills exactly two entries, then drains in order
      for (int r = 0; r < 4; r++) begin
         lat = tbl[r].lat;
         for (int i = 0; i < tbl[r].stall; i++) cycle(0, 0, 0);
         chk("stall_req", 32'(mem_req), 32'(tbl[r].exp_req));
         chk("stall_valid", 32'(instr_valid), 32'h1);
         lat = tbl[r].drain_lat;
         cycle(1, 0, 0);
         chk("drain_v0", 32'(instr_valid), 32'(tbl[r].exp_v0));
         cycle(1, 0, 0);
         chk("drain_v1", 32'(instr_valid), 32'(tbl[r].exp_v1));
         cycle(1, 0, 0);
         chk("drain_v2", 32'(instr_valid), 32'(tbl[r].exp_v2));
         for (int i = 0; i < 6; i++) cycle(1, 0, 0);
      end

      // redirect while the 0x108 request is still waiting
      lat = 5;
      do_reset();
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         cycle(1, 0, 0);
         found = mem_req && (mem_addr == 32'h108);
      end
      chk("wait_108", 32'(found), 32'h1);
      cycle(1, 1, 32'h200);
      cycle(1, 0, 0);
      chk("disc_addr", mem_addr, 32'h108);
      p0 = pops;
      for (int n = 0; n < 60 && pops == p0; n++) cycle(1, 0, 0);
      chk("disc_progress", 32'(pops != p0), 32'h1);

      // redirect in the same cycle as an ack and a pop
      lat = 0;
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 0, 0);
      cycle(1, 1, 32'h200);
      chk("coinc_valid", 32'(instr_valid), 32'h1);
      cycle(1, 0, 0);
      chk("coinc_addr", mem_addr, 32'h200);
      chk("coinc_req", 32'(mem_req), 32'h1);
      p0 = pops;
      for (int n = 0; n < 20 && pops == p0; n++) cycle(1, 0, 0);
      chk("coinc_progress", 32'(pops != p0), 32'h1);

      // misaligned redirect
      for (int i = 0; i < 4; i++) cycle(1, 0, 0);
      cycle(1, 1, 32'h202);
      cycle(1, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_fault", 32'(fetch_fault), 32'h1);
      chk("mis_fault_pc", fault_pc, 32'h202);
      chk("mis_req", 32'(mem_req), 32'h0);
      for (int i = 0; i < 10; i++) cycle(1, 0, 0);
      lat = 4;
      do_reset();
      for (int i = 0; i < 2; i++) cycle(1, 0, 0);
      cycle(1, 1, 32'h306);
      for (int i = 0; i < 10; i++) cycle(1, 0, 0);
      chk("mis_wait_fault_pc", fault_pc, 32'h306);
      chk("mis_wait_req", 32'(mem_req), 32'h0);
`else
      chk("mis_fault", 32'(fetch_fault), 32'h0);
      chk("mis_fault_pc", fault_pc, 32'h0);
      p0 = pops;
      for (int n = 0; n < 20 && pops == p0; n++) cycle(1, 0, 0);
      chk("mis_progress", 32'(pops != p0), 32'h1);
`endif

      // random traffic, random latency, occasional redirects including a wrap target
      do_reset();
      rnd_lat = 1'b1;
      p0 = pops;
      for (int i = 0; i < 3000; i++) begin
         rpc = $urandom;
         if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
`ifdef FETCH_ALIGN_CHECK_EN
         rpc[1:0] = 2'b00;
`endif
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, rpc);
      end
      chk("rand_progress", 32'(pops - p0 > 300), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
